// File: rtl/sync_hs_src.sv
// Source side of a 4-phase req/ack crossing: captures a word, drives the request synchronizer
// and synchronizes the returning acknowledge. Optional ack timeout flag: SYNC_HS_TIMEOUT_EN.
`timescale 1ns/1ps

module sync_hs_src #(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  INIT    = '0,
    parameter int unsigned       TIMEOUT = 1023
) (
    input  logic             sCLK,
    input  logic             sRST,
    input  logic             sENQ,
    input  logic [WIDTH-1:0] sD_IN,
    output logic             sRDY,
    output logic             sREQ_EN,
    output logic             sREQ_D,
    output logic             sREQ,
    output logic [WIDTH-1:0] dDATA,
    input  logic             dACK,
    output logic             sDONE,
    output logic             sERR
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWaitHi = 2'd1;
    localparam logic [1:0] StWaitLo = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ack_s1_q, ack_s2_q;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;

    // dACK is asynchronous; only ack_s2_q may reach the FSM.
    always_ff @(posedge sCLK or negedge sRST) begin
        if (!sRST) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
        end else begin
            ack_s1_q <= dACK;
            ack_s2_q <= ack_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (sENQ) begin
                    data_d  = sD_IN;
                    req_d   = 1'b1;
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                if (ack_s2_q) begin
                    req_d   = 1'b0;
                    state_d = StWaitLo;
                end
            end
            StWaitLo: begin
                if (!ack_s2_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sCLK or negedge sRST) begin
        if (!sRST) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            data_q  <= INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign sRDY    = (state_q == StIdle);
    assign sREQ    = req_q;
    assign dDATA   = data_q;
    assign sDONE   = done_q;
    // Gated by reset so the synchronizer sees no enable while the source is held in reset.
    assign sREQ_EN = sRST & (req_d ^ req_q);
    assign sREQ_D  = sRST & req_d;

`ifdef SYNC_HS_TIMEOUT_EN
    localparam logic [15:0] TimeoutCnt = TIMEOUT[15:0];

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        waiting;

    // Counter restarts on every state change and saturates rather than wrapping.
    always_comb begin
        waiting = (state_d == StWaitHi) || (state_d == StWaitLo);
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
        if ((state_d == state_q) && waiting && (cnt_d == TimeoutCnt)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge sCLK or negedge sRST) begin
        if (!sRST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign sERR = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign sERR = 1'b0;
`endif

endmodule

// File: tb/tb_sync_hs_src.sv
// Bench for sync_hs_src: directed steps plus random enqueues checked against a transfer-level
// timing model; the timeout section runs only when SYNC_HS_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_sync_hs_src;

    localparam int unsigned  W      = 8;
    localparam logic [W-1:0] INIT_V = 8'h5A;
    localparam int unsigned  TO     = 10;

    logic         sCLK = 1'b0;
    logic         sRST = 1'b1;
    logic         sENQ = 1'b0;
    logic [W-1:0] sD_IN = '0;
    logic         dACK = 1'b0;
    logic         sRDY, sREQ_EN, sREQ_D, sREQ, sDONE, sERR;
    logic [W-1:0] dDATA;

    sync_hs_src #(
        .WIDTH   (W),
        .INIT    (INIT_V),
        .TIMEOUT (TO)
    ) dut (
        .sCLK    (sCLK),
        .sRST    (sRST),
        .sENQ    (sENQ),
        .sD_IN   (sD_IN),
        .sRDY    (sRDY),
        .sREQ_EN (sREQ_EN),
        .sREQ_D  (sREQ_D),
        .sREQ    (sREQ),
        .dDATA   (dDATA),
        .dACK    (dACK),
        .sDONE   (sDONE),
        .sERR    (sERR)
    );

    always #5 sCLK = ~sCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;

    // Transfer model: accept at edge n, ack delays d/f => sREQ high for edges [n, n+d+3),
    // idle + done pulse from edge n+d+f+6.
    bit           m_have = 1'b0;
    int           m_acc  = 0;
    int           m_d    = 3;
    int           m_f    = 3;
    logic [W-1:0] m_data = INIT_V;
    int           next_d = 3;
    int           next_f = 3;

    // Destination responder: dACK follows sREQ after dly_rise / dly_fall cycles.
    bit   dst_auto = 1'b0;
    logic dst_prev = 1'b0;
    int   dst_cnt  = 0;
    int   dly_rise = 3;
    int   dly_fall = 3;

    int obs_en   = 0;
    int obs_done = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_rdy();
        return !m_have || (e >= m_acc + m_d + m_f + 6);
    endfunction

    function automatic bit m_req();
        return m_have && (e >= m_acc) && (e < m_acc + m_d + 3);
    endfunction

    function automatic bit m_done();
        return m_have && (e == m_acc + m_d + m_f + 6);
    endfunction

    function automatic bit m_fall_next();
        return m_have && (e == m_acc + m_d + 2);
    endfunction

    task automatic dest_step();
        if (sREQ !== dst_prev) begin
            dst_prev = sREQ;
            dst_cnt  = 0;
        end else begin
            dst_cnt++;
        end
        if (dst_auto && (dst_cnt == (dst_prev ? dly_rise : dly_fall))) dACK = dst_prev;
    endtask

    task automatic clk1();
        @(posedge sCLK);
        #1;
        e++;
        dest_step();
    endtask

    task automatic check_reset_vals(input string tag);
        check1({tag, "_rdy"}, sRDY, 1'b1);
        check1({tag, "_req"}, sREQ, 1'b0);
        check1({tag, "_req_en"}, sREQ_EN, 1'b0);
        check1({tag, "_req_d"}, sREQ_D, 1'b0);
        checkw({tag, "_data"}, dDATA, INIT_V);
        check1({tag, "_done"}, sDONE, 1'b0);
        check1({tag, "_err"}, sERR, 1'b0);
    endtask

    // One model-checked cycle: drive inputs, check combinational request outputs, clock,
    // then check registered outputs against the model.
    task automatic cycle(input logic enq, input logic [W-1:0] din);
        bit   acc;
        logic exp_d;
        sENQ  = enq;
        sD_IN = din;
        #1;
        acc   = enq && m_rdy();
        exp_d = acc ? 1'b1 : (m_fall_next() ? 1'b0 : m_req());
        check1("req_en", sREQ_EN, acc || m_fall_next());
        check1("req_d", sREQ_D, exp_d);
        if (sREQ_EN === 1'b1) obs_en++;
        @(posedge sCLK);
        #1;
        e++;
        if (acc) begin
            m_have   = 1'b1;
            m_acc    = e;
            m_d      = next_d;
            m_f      = next_f;
            m_data   = din;
            dly_rise = next_d;
            dly_fall = next_f;
        end
        dest_step();
        check1("rdy", sRDY, m_rdy());
        check1("req", sREQ, m_req());
        checkw("data", dDATA, m_data);
        check1("done", sDONE, m_done());
        check1("err", sERR, 1'b0);
        if (sDONE === 1'b1) obs_done++;
    endtask

    initial begin
        #(100_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with sENQ high: request outputs must stay quiet.
        sENQ  = 1'b1;
        sD_IN = 8'hFF;
        #1 sRST = 1'b0;
        #1;
        check_reset_vals("rst");
        repeat (2) @(posedge sCLK);
        #1;
        sENQ = 1'b0;
        sRST = 1'b1;

        repeat (3) cycle(1'b0, 8'h00);

        // Single transfer of 0xA5 with 3-cycle destination delays.
        dst_auto = 1'b1;
        obs_en   = 0;
        obs_done = 0;
        cycle(1'b1, 8'hA5);
        repeat (14) cycle(1'b0, W'($urandom));
        checki("a5_req_en_pulses", obs_en, 2);
        checki("a5_done_pulses", obs_done, 1);
        checkw("a5_data_hold", dDATA, 8'hA5);

        // sENQ held high with the word changing every cycle.
        obs_done = 0;
        for (int i = 0; i < 40; i++) cycle(1'b1, W'(i % 3 + 1));
        repeat (14) cycle(1'b0, 8'h00);
        checki("held_enq_transfers", obs_done, 4);

        // Half-cycle dACK glitch in IDLE.
        dst_auto = 1'b0;
        sENQ = 1'b0;
        dACK = 1'b1;
        #3 dACK = 1'b0;
        repeat (3) clk1();
        check1("glitch_idle_rdy", sRDY, 1'b1);
        check1("glitch_idle_req", sREQ, 1'b0);
        check1("glitch_idle_done", sDONE, 1'b0);

        // Enter WAIT_HI manually, glitch again, then reset with dACK high.
        sENQ  = 1'b1;
        sD_IN = 8'h77;
        clk1();
        sENQ = 1'b0;
        check1("wh_req", sREQ, 1'b1);
        check1("wh_rdy", sRDY, 1'b0);
        checkw("wh_data", dDATA, 8'h77);
        dACK = 1'b1;
        #3 dACK = 1'b0;
        repeat (4) clk1();
        check1("glitch_wh_req", sREQ, 1'b1);
        check1("glitch_wh_rdy", sRDY, 1'b0);
        check1("glitch_wh_req_en", sREQ_EN, 1'b0);
        dACK = 1'b1;
        repeat (2) clk1();
        check1("wh_ack_req", sREQ, 1'b1);
        #2 sRST = 1'b0;
        #1;
        check_reset_vals("midrst");
        dACK = 1'b0;
        repeat (2) clk1();
        sRST = 1'b1;
        repeat (3) clk1();
        check1("postrst_rdy", sRDY, 1'b1);
        check1("postrst_req", sREQ, 1'b0);

        m_have   = 1'b0;
        m_data   = INIT_V;
        next_d   = 3;
        next_f   = 3;
        dst_auto = 1'b1;
        obs_done = 0;
        cycle(1'b1, 8'h3C);
        repeat (14) cycle(1'b0, 8'h00);
        checkw("3c_data", dDATA, 8'h3C);
        checki("3c_done_pulses", obs_done, 1);

        // Random enqueues with random destination delays.
        for (int i = 0; i < 200; i++) begin
            next_d = int'($urandom_range(1, 4));
            next_f = int'($urandom_range(1, 4));
            cycle(($urandom_range(0, 2) == 0), W'($urandom));
        end
        repeat (20) cycle(1'b0, 8'h00);

`ifdef SYNC_HS_TIMEOUT_EN
        dst_auto = 1'b0;
        dACK  = 1'b0;
        sENQ  = 1'b1;
        sD_IN = 8'hC3;
        clk1();
        sENQ = 1'b0;
        repeat (9) clk1();
        check1("to_err_early", sERR, 1'b0);
        clk1();
        check1("to_err_set", sERR, 1'b1);
        repeat (5) clk1();
        check1("to_err_sticky", sERR, 1'b1);
        check1("to_still_waiting", sREQ, 1'b1);
        dACK = 1'b1;
        clk1();
        check1("to_req_m", sREQ, 1'b1);
        clk1();
        check1("to_req_m1", sREQ, 1'b1);
        clk1();
        check1("to_req_fall", sREQ, 1'b0);
        dACK = 1'b0;
        repeat (2) clk1();
        check1("to_rdy_k1", sRDY, 1'b0);
        clk1();
        check1("to_rdy_k2", sRDY, 1'b1);
        check1("to_done", sDONE, 1'b1);
        check1("to_err_after", sERR, 1'b1);
        clk1();
        check1("to_done_drop", sDONE, 1'b0);
        check1("to_err_final", sERR, 1'b1);
`else
        check1("err_off", sERR, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
